imem_loader: RTL and testbench

- Boot-time program loader: the writer side of the instruction-memory interface that the CPU fetches from.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory and holds the CPU in reset until the whole image is loaded and its checksum verified.
- Sits between the host/bench byte source and the top level, alongside the pipeline stages; drives the CPU reset and the instruction-memory write port.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 13 +
 rtl/imem_loader_packer.sv | 46 ++++
 rtl/imem_loader.sv | 109 ++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Holds the loader FSM state encoding and the frame geometry constant.
// No logic; imported by the loader top and its byte packer.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        RUN    = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // States in which the loader is willing to take a stream byte.
    function automatic logic accepts_bytes(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the host byte source and the loader.
// A byte moves on a rising edge where in_valid && in_ready; no added latency.
// master drives in_data/in_valid, slave drives in_ready (slave applies backpressure).
interface imem_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/imem_loader_packer.sv
// Packs accepted stream bytes MSB-first into 32-bit words.
// Latency: word_valid/word appear one cycle after the edge that takes the 4th byte.
// Backpressure: none of its own; byte_vld must already be a completed transfer.
// Ports: clk/rst, byte_vld/byte_dat in, last_byte (current byte completes a word),
//        word_valid (1-cycle pulse) and word (held until the next completed word).
module imem_loader_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0] cnt;
    // Only the first three bytes need storing; the fourth is merged straight
    // into the output word on the edge that accepts it.
    logic [23:0]   shift;

    assign last_byte = (cnt == CW'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            shift      <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (byte_vld) begin
                shift <= {shift[15:0], byte_dat};
                cnt   <= cnt + CW'(1);   // wraps back to 0 after the last byte
                if (last_byte) begin
                    word       <= {shift, byte_dat};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a framed byte stream, writes instruction memory, releases CPU reset.
// Latency: memory write one cycle after a word's 4th byte; cpu_rst drops on the checksum edge.
// Backpressure: in_ready high while loading, low once RUN or ERROR is reached.
// Ports: clk, rst (sync, active-high); in_if byte stream (slave); mem_we/mem_addr/mem_wdata
//        write port; cpu_rst, done, error status; words_loaded = words written so far.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_loader_if.slave          in_if,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [7:0]  csum;
    logic        xfer;
    logic        pk_vld;
    logic        pk_last;
    logic        word_done;

    assign xfer      = in_if.in_valid && in_if.in_ready;
    assign pk_vld    = xfer && (state == DATA);
    assign word_done = pk_vld && pk_last;
    // Length as it will be once the low byte currently on the bus is latched.
    assign len_full  = {len[15:8], in_if.in_data};

    imem_loader_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_vld   (pk_vld),
        .byte_dat   (in_if.in_data),
        .last_byte  (pk_last),
        .word_valid (mem_we),
        .word       (mem_wdata)
    );

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            case (state)
                LEN_HI: state_nxt = LEN_LO;
                LEN_LO: begin
                    if ({16'd0, len_full} > 32'(DEPTH))
                        state_nxt = ERROR;
                    else if (len_full == 16'd0)
                        state_nxt = CHECK;
                    else
                        state_nxt = DATA;
                end
                DATA: begin
                    // Leave DATA on the edge that completes the last word.
                    if (pk_last && (32'(words_loaded) + 32'd1 == {16'd0, len}))
                        state_nxt = CHECK;
                end
                CHECK:   state_nxt = (in_if.in_data == csum) ? RUN : ERROR;
                default: state_nxt = state;
            endcase
        end
    end

    // Status outputs are registered decodes of the state being entered, so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LEN_HI;
            in_if.in_ready <= 1'b1;
            cpu_rst        <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            len            <= '0;
            csum           <= '0;
            words_loaded   <= '0;
            mem_addr       <= '0;
        end else begin
            state          <= state_nxt;
            in_if.in_ready <= accepts_bytes(state_nxt);
            done           <= (state_nxt == RUN);
            error          <= (state_nxt == ERROR);
            cpu_rst        <= (state_nxt != RUN);

            // The checksum covers every frame byte except the checksum itself.
            if (xfer && (state != CHECK))
                csum <= csum ^ in_if.in_data;
            if (xfer && (state == LEN_HI))
                len[15:8] <= in_if.in_data;
            if (xfer && (state == LEN_LO))
                len[7:0] <= in_if.in_data;

            if (word_done) begin
                mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
// Expected writes are queued as each word's last byte is driven and retired on mem_we.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_imem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic            cpu_rst;
    logic            done;
    logic            error;
    logic [AW:0]     words_loaded;

    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_if        (bus),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    int          writes_seen = 0;
    wr_t         exp_q[$];
    logic [31:0] img [0:DEPTH-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard retirement: every write must match the oldest queued word.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            writes_seen++;
            chk("write_was_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(mem_addr), 64'(e.addr));
                chk("write_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok = bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_cpu_rst"},  64'(cpu_rst), 64'd1);
        chk({tag, "_done"},     64'(done), 64'd0);
        chk({tag, "_error"},    64'(error), 64'd0);
        chk({tag, "_mem_we"},   64'(mem_we), 64'd0);
        chk({tag, "_words"},    64'(words_loaded), 64'd0);
        chk({tag, "_addr"},     64'(mem_addr), 64'd0);
        chk({tag, "_wdata"},    64'(mem_wdata), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        check_reset(tag);
        rst = 1'b0;
    endtask

    // Sends a frame declaring n words from img[]. stop_at >= 0 abandons the
    // frame after that many data bytes. bad flips the checksum.
    task automatic send_frame(input int n, input bit bad, input int maxgap, input int stop_at);
        logic [7:0]  c;
        logic [7:0]  b;
        logic [15:0] len16;
        bit          ok;
        int          sent;
        c     = 8'h00;
        sent  = 0;
        len16 = 16'(n);
        send_byte(len16[15:8], 0, ok);
        chk("len_hi_accepted", 64'(ok), 64'd1);
        c = c ^ len16[15:8];
        send_byte(len16[7:0], $urandom_range(maxgap, 0), ok);
        chk("len_lo_accepted", 64'(ok), 64'd1);
        c = c ^ len16[7:0];
        if (n > DEPTH) return;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (stop_at >= 0 && sent == stop_at) return;
                b = img[w][31 - 8*k -: 8];
                if (k == 3) exp_q.push_back('{addr: AW'(w), data: img[w]});
                send_byte(b, $urandom_range(maxgap, 0), ok);
                if (!ok) begin
                    chk("data_byte_accepted", 64'(ok), 64'd1);
                end
                c = c ^ b;
                sent++;
                if (k == 3) chk("write_latency_1", 64'(mem_we), 64'd1);
            end
        end
        chk("done_low_before_cks", 64'(done), 64'd0);
        send_byte(c ^ {7'd0, bad}, $urandom_range(maxgap, 0), ok);
        chk("cks_accepted", 64'(ok), 64'd1);
    endtask

    task automatic check_run(input string tag, input int nwords);
        chk({tag, "_done"},     64'(done), 64'd1);
        chk({tag, "_cpu_rst"},  64'(cpu_rst), 64'd0);
        chk({tag, "_error"},    64'(error), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_words"},    64'(words_loaded), 64'(nwords));
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_err(input string tag, input int nwords);
        chk({tag, "_error"},    64'(error), 64'd1);
        chk({tag, "_cpu_rst"},  64'(cpu_rst), 64'd1);
        chk({tag, "_done"},     64'(done), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_words"},    64'(words_loaded), 64'(nwords));
    endtask

    initial begin
        bit ok;
        int base;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        // Two-word frame, back-to-back, correct checksum.
        img[0] = 32'h2008_0005;
        img[1] = 32'h0000_0000;
        base = writes_seen;
        send_frame(2, 1'b0, 0, -1);
        check_run("good2", 2);
        chk("good2_writes", 64'(writes_seen - base), 64'd2);
        // Stream keeps offering bytes in RUN: nothing is consumed.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        check_run("run_hold", 2);
        chk("run_hold_writes", 64'(writes_seen - base), 64'd2);

        // Same frame, checksum off by one bit.
        do_reset("rst_a");
        base = writes_seen;
        send_frame(2, 1'b1, 0, -1);
        check_err("badcks", 2);
        chk("badcks_writes", 64'(writes_seen - base), 64'd2);

        // Declared length one past capacity.
        do_reset("rst_b");
        base = writes_seen;
        send_frame(DEPTH + 1, 1'b0, 0, -1);
        check_err("ovf", 0);
        send_byte(8'h11, 0, ok);
        chk("ovf_byte_refused", 64'(ok), 64'd0);
        repeat (4) @(negedge clk);
        chk("ovf_no_writes", 64'(writes_seen - base), 64'd0);

        // Empty image, good then bad checksum.
        do_reset("rst_c");
        send_frame(0, 1'b0, 0, -1);
        check_run("empty_ok", 0);
        do_reset("rst_d");
        send_frame(0, 1'b1, 0, -1);
        check_err("empty_bad", 0);

        // One word with random valid gaps.
        do_reset("rst_e");
        img[0] = 32'hDEAD_BEEF;
        base = writes_seen;
        send_frame(1, 1'b0, 3, -1);
        check_run("gaps", 1);
        chk("gaps_writes", 64'(writes_seen - base), 64'd1);

        // Abort a two-word frame mid-word, then load a fresh frame.
        do_reset("rst_f");
        img[0] = 32'h0102_0304;
        img[1] = 32'hA0B0_C0D0;
        base = writes_seen;
        send_frame(2, 1'b0, 0, 6);
        chk("abort_partial_writes", 64'(writes_seen - base), 64'd1);
        do_reset("abort_rst");
        repeat (2) @(negedge clk);
        img[0] = 32'h1357_9BDF;
        img[1] = 32'h2468_ACE0;
        base = writes_seen;
        send_frame(2, 1'b0, 1, -1);
        check_run("reload", 2);
        chk("reload_writes", 64'(writes_seen - base), 64'd2);

        // Full-capacity image: addresses 0..DEPTH-1, no wrap.
        do_reset("rst_g");
        for (int i = 0; i < DEPTH; i++) img[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
        base = writes_seen;
        send_frame(DEPTH, 1'b0, 0, -1);
        check_run("full", DEPTH);
        chk("full_writes", 64'(writes_seen - base), 64'(DEPTH));
        chk("full_last_addr", 64'(mem_addr), 64'(DEPTH - 1));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
